// File: rtl/ring_mem_station_pkg.sv
// Shared ring definitions: slot-type codes, Address-slot layout and station FSM states.
// Used by the memory station and by the memory multiplexer.
package ring_mem_station_pkg;

    typedef enum logic [3:0] {
        SLOT_TOKEN      = 4'd1,
        SLOT_ADDRESS    = 4'd2,
        SLOT_WRITE_DATA = 4'd3,
        SLOT_NULL       = 4'd7
    } slot_type_e;

    localparam int ADDR_READ_BIT  = 28;
    localparam int ADDR_INSTR_BIT = 29;
    localparam int ADDR_WIDTH     = 26;
    localparam int LINE_WORDS     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TOKEN,
        ST_SEND,
        ST_FWD_TOKEN,
        ST_WAIT_READ
    } station_state_e;

    typedef struct packed {
        logic                             write;
        logic [ADDR_WIDTH-1:0]            addr;
        logic [LINE_WORDS-1:0][31:0]      wdata;
    } mem_req_t;

    function automatic logic [31:0] address_slot(input logic read, input logic instr,
                                                 input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] slot;
        slot                 = '0;
        slot[ADDR_WIDTH-1:0] = addr;
        slot[ADDR_READ_BIT]  = read;
        slot[ADDR_INSTR_BIT] = instr;
        return slot;
    endfunction

endpackage

// File: rtl/ring_mem_station_if.sv
// Core-side request/response bundle of the ring memory station.
interface ring_mem_station_if;
    import ring_mem_station_pkg::*;

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_WIDTH-1:0]        req_addr;
    logic [LINE_WORDS*32-1:0]     req_wdata;
    logic                         rsp_valid;
    logic [31:0]                  rsp_data;
    logic                         rsp_last;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/ring_slot_reg.sv
// Downstream ring slot register; null_insert replaces the slot with an empty Null slot.
module ring_slot_reg
    import ring_mem_station_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        null_insert,
    input  logic [3:0]  type_d,
    input  logic [3:0]  source_d,
    input  logic [31:0] data_d,
    output logic [3:0]  type_q,
    output logic [3:0]  source_q,
    output logic [31:0] data_q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || null_insert) begin
            type_q   <= SLOT_NULL;
            source_q <= '0;
            data_q   <= '0;
        end else begin
            type_q   <= type_d;
            source_q <= source_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/ring_mem_station.sv
// Ring memory station: turns one core cache-line request into ring slots after capturing
// the token, forwards the bumped token, and collects the eight-word read return.
module ring_mem_station
    import ring_mem_station_pkg::*;
#(
    parameter logic [3:0] STATION_ID = 4'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SourceIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SourceOut,
    input  logic [31:0] RDreturn,
    input  logic [3:0]  RDdest,
    ring_mem_station_if.slave core,
    output logic        protocol_err
);

    station_state_e state_q, state_d;
    mem_req_t       req_q;
    logic [7:0]     token_count_q;
    logic [2:0]     slot_idx_q;
    logic [2:0]     word_count_q;

    logic        handshake, own_slot, token_in, rd_hit, null_insert;
    logic [2:0]  last_slot;
    logic [1:0]  word_sel;
    logic [7:0]  slot_count, token_sum;
    logic [3:0]  type_d, source_d;
    logic [31:0] data_d;

    assign core.req_ready = (state_q == ST_IDLE) && !reset;
    assign handshake      = core.req_valid && core.req_ready;
    assign own_slot       = ((SlotTypeIn == SLOT_ADDRESS) || (SlotTypeIn == SLOT_WRITE_DATA))
                            && (SourceIn == STATION_ID);
    assign token_in       = (SlotTypeIn == SLOT_TOKEN);
    assign rd_hit         = (RDdest == STATION_ID);
    assign last_slot      = req_q.write ? 3'd4 : 3'd0;
    assign slot_count     = req_q.write ? 8'd5 : 8'd1;
    assign token_sum      = token_count_q + slot_count;
    assign word_sel       = 2'(slot_idx_q - 3'd1);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        type_d      = SlotTypeIn;
        source_d    = SourceIn;
        data_d      = RingIn;
        null_insert = own_slot;
        case (state_q)
            ST_IDLE: if (handshake) state_d = ST_WAIT_TOKEN;
            ST_WAIT_TOKEN: begin
                if (token_in) begin
                    null_insert = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                // Arrivals here should be Null; whatever came in is overwritten by our slot.
                null_insert = 1'b0;
                source_d    = STATION_ID;
                if (slot_idx_q == 3'd0) begin
                    type_d = SLOT_ADDRESS;
                    data_d = address_slot(!req_q.write, 1'b0, req_q.addr);
                end else begin
                    type_d = SLOT_WRITE_DATA;
                    data_d = req_q.wdata[word_sel];
                end
                if (slot_idx_q == last_slot) state_d = ST_FWD_TOKEN;
            end
            ST_FWD_TOKEN: begin
                null_insert = 1'b0;
                type_d      = SLOT_TOKEN;
                source_d    = STATION_ID;
                data_d      = {24'd0, token_sum};
                state_d     = req_q.write ? ST_IDLE : ST_WAIT_READ;
            end
            ST_WAIT_READ: if (rd_hit && (word_count_q == 3'd7)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            slot_idx_q     <= '0;
            word_count_q   <= '0;
            protocol_err   <= 1'b0;
            core.rsp_valid <= 1'b0;
            core.rsp_last  <= 1'b0;
        end else begin
            state_q        <= state_d;
            core.rsp_valid <= 1'b0;
            core.rsp_last  <= 1'b0;
            if (state_q == ST_SEND)
                slot_idx_q <= (state_d == ST_SEND) ? slot_idx_q + 3'd1 : 3'd0;
            if (rd_hit) begin
                if (state_q == ST_WAIT_READ) begin
                    core.rsp_valid <= 1'b1;
                    core.rsp_last  <= (word_count_q == 3'd7);
                    word_count_q   <= word_count_q + 3'd1;
                end else begin
                    protocol_err <= 1'b1;
                end
            end
            if ((state_q == ST_SEND) && (SlotTypeIn != SLOT_NULL)) protocol_err <= 1'b1;
        end
    end

    // NOTE: payload registers carry no reset; they are only read after a load qualifies them.
    always_ff @(posedge clock) begin
        if (handshake) req_q <= '{write: core.req_write, addr: core.req_addr, wdata: core.req_wdata};
        if ((state_q == ST_WAIT_TOKEN) && token_in) token_count_q <= RingIn[7:0];
        if (rd_hit && (state_q == ST_WAIT_READ)) core.rsp_data <= RDreturn;
    end

    ring_slot_reg u_slot_reg (
        .clock       (clock),
        .reset       (reset),
        .null_insert (null_insert),
        .type_d      (type_d),
        .source_d    (source_d),
        .data_d      (data_d),
        .type_q      (SlotTypeOut),
        .source_q    (SourceOut),
        .data_q      (RingOut)
    );

endmodule

// File: tb/tb_ring_mem_station.sv
// Directed self-checking bench for ring_mem_station: writes, reads, wrap, own-slot removal,
// protocol violations and reset mid-read.
module tb_ring_mem_station;
    import ring_mem_station_pkg::*;

    localparam logic [3:0] SID = 4'd5;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] RingIn, RingOut, RDreturn;
    logic [3:0]  SlotTypeIn, SourceIn, SlotTypeOut, SourceOut, RDdest;
    logic        protocol_err;
    int          checks = 0;
    int          errors = 0;

    ring_mem_station_if bus ();

    ring_mem_station #(.STATION_ID(SID)) dut (
        .clock        (clock),
        .reset        (reset),
        .RingIn       (RingIn),
        .SlotTypeIn   (SlotTypeIn),
        .SourceIn     (SourceIn),
        .RingOut      (RingOut),
        .SlotTypeOut  (SlotTypeOut),
        .SourceOut    (SourceOut),
        .RDreturn     (RDreturn),
        .RDdest       (RDdest),
        .core         (bus.slave),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic ring_drive(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
        SlotTypeIn = t;
        SourceIn   = s;
        RingIn     = d;
    endtask

    task automatic expect_slot(input string tag, input logic [3:0] t, input logic [3:0] s,
                               input logic [31:0] d);
        tick();
        check({tag, ".type"}, SlotTypeOut, t);
        check({tag, ".src"}, SourceOut, s);
        check({tag, ".data"}, RingOut, d);
    endtask

    // Handshake one request, then deliver the token and check it is absorbed.
    task automatic issue(input logic wr, input logic [25:0] a, input logic [127:0] wd,
                         input logic [7:0] cnt);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        tick();
        check("req_ready_busy", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        ring_drive(SLOT_TOKEN, 4'd9, 32'hABCDEF00 | {24'd0, cnt});
        tick();
        check("token_absorbed", SlotTypeOut, SLOT_NULL);
        ring_drive(SLOT_NULL, 4'd0, 32'd0);
    endtask

    task automatic read_words(input string tag, input int count);
        for (int i = 0; i < count; i++) begin
            RDdest   = SID;
            RDreturn = 32'hA5000000 | i;
            tick();
            check({tag, ".valid"}, bus.rsp_valid, 1'b1);
            check({tag, ".data"}, bus.rsp_data, 32'hA5000000 | i);
            check({tag, ".last"}, bus.rsp_last, (i == 7));
            RDdest = 4'd0;
            tick();
            check({tag, ".gap_valid"}, bus.rsp_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        RDdest        = 4'd0;
        RDreturn      = 32'd0;
        ring_drive(SLOT_TOKEN, 4'd2, 32'h77);
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_last", bus.rsp_last, 1'b0);
        check("rst_type", SlotTypeOut, SLOT_NULL);
        check("rst_data", RingOut, 32'd0);
        check("rst_src", SourceOut, 4'd0);
        check("rst_err", protocol_err, 1'b0);
        reset = 1'b0;
        ring_drive(SLOT_NULL, 4'd0, 32'd0);
        tick();
        check("idle_req_ready", bus.req_ready, 1'b1);

        // Pass-through, foreign token, own-slot removal, foreign Address
        ring_drive(4'hA, 4'd3, 32'hDEADBEEF);
        expect_slot("pass_other", 4'hA, 4'd3, 32'hDEADBEEF);
        ring_drive(SLOT_TOKEN, 4'd2, 32'h55);
        expect_slot("pass_token", SLOT_TOKEN, 4'd2, 32'h55);
        ring_drive(SLOT_ADDRESS, SID, 32'h123);
        expect_slot("own_removed", SLOT_NULL, 4'd0, 32'd0);
        ring_drive(SLOT_WRITE_DATA, SID, 32'h321);
        expect_slot("own_wd_removed", SLOT_NULL, 4'd0, 32'd0);
        ring_drive(SLOT_ADDRESS, 4'd3, 32'h456);
        expect_slot("foreign_addr", SLOT_ADDRESS, 4'd3, 32'h456);
        ring_drive(SLOT_NULL, 4'd0, 32'd0);

        // Write line, token count 3 -> 8
        issue(1'b1, 26'h0000100, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 8'd3);
        expect_slot("wr_addr", SLOT_ADDRESS, SID, 32'h00000100);
        expect_slot("wr_w0", SLOT_WRITE_DATA, SID, 32'h11111111);
        expect_slot("wr_w1", SLOT_WRITE_DATA, SID, 32'h22222222);
        expect_slot("wr_w2", SLOT_WRITE_DATA, SID, 32'h33333333);
        expect_slot("wr_w3", SLOT_WRITE_DATA, SID, 32'h44444444);
        expect_slot("wr_token", SLOT_TOKEN, SID, 32'h00000008);
        check("wr_req_ready", bus.req_ready, 1'b1);
        check("wr_err", protocol_err, 1'b0);

        // Read line, token count 0 -> 1, eight words with gaps
        issue(1'b0, 26'h3FFFFC0, '0, 8'd0);
        expect_slot("rd_addr", SLOT_ADDRESS, SID, 32'h13FFFFC0);
        expect_slot("rd_token", SLOT_TOKEN, SID, 32'h00000001);
        check("rd_wait_ready", bus.req_ready, 1'b0);
        read_words("rd", 8);
        check("rd_done_ready", bus.req_ready, 1'b1);
        check("rd_err", protocol_err, 1'b0);

        // Token count wraps
        issue(1'b1, 26'h1234567, {32'hD, 32'hC, 32'hB, 32'hA}, 8'hFE);
        expect_slot("wrap_addr", SLOT_ADDRESS, SID, 32'h01234567);
        expect_slot("wrap_w0", SLOT_WRITE_DATA, SID, 32'hA);
        expect_slot("wrap_w1", SLOT_WRITE_DATA, SID, 32'hB);
        expect_slot("wrap_w2", SLOT_WRITE_DATA, SID, 32'hC);
        expect_slot("wrap_w3", SLOT_WRITE_DATA, SID, 32'hD);
        expect_slot("wrap_token", SLOT_TOKEN, SID, 32'h00000003);

        // Non-Null arrival during SEND, then reset after three read words
        issue(1'b0, 26'h0000040, '0, 8'h10);
        ring_drive(SLOT_ADDRESS, 4'd3, 32'h777);
        expect_slot("viol_addr", SLOT_ADDRESS, SID, 32'h10000040);
        check("viol_send_err", protocol_err, 1'b1);
        ring_drive(SLOT_NULL, 4'd0, 32'd0);
        expect_slot("viol_token", SLOT_TOKEN, SID, 32'h00000011);
        read_words("part", 3);
        check("err_sticky", protocol_err, 1'b1);
        reset  = 1'b1;
        RDdest = SID;
        tick();
        check("mid_rst_ready", bus.req_ready, 1'b0);
        check("mid_rst_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_type", SlotTypeOut, SLOT_NULL);
        check("mid_rst_err", protocol_err, 1'b0);
        reset  = 1'b0;
        RDdest = 4'd0;
        tick();
        check("post_rst_ready", bus.req_ready, 1'b1);
        check("post_rst_valid", bus.rsp_valid, 1'b0);
        check("post_rst_no_token", SlotTypeOut, SLOT_NULL);

        // Counter must restart at zero: rsp_last only on the eighth word
        issue(1'b0, 26'h0000080, '0, 8'h20);
        expect_slot("rd2_addr", SLOT_ADDRESS, SID, 32'h10000080);
        expect_slot("rd2_token", SLOT_TOKEN, SID, 32'h00000021);
        read_words("rd2", 8);
        check("rd2_done_ready", bus.req_ready, 1'b1);
        check("rd2_err", protocol_err, 1'b0);

        // RDdest match while IDLE
        RDdest   = SID;
        RDreturn = 32'hBAD0BAD0;
        tick();
        check("idle_hit_valid", bus.rsp_valid, 1'b0);
        check("idle_hit_err", protocol_err, 1'b1);
        RDdest = 4'd0;
        tick();
        tick();
        check("idle_hit_sticky", protocol_err, 1'b1);
        check("idle_hit_ready", bus.req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_mem_station.md
RING_MEM_STATION -- requirements
Module: ring_mem_station

Interface
REQ-001 Parameter STATION_ID, default 1, ring station number (1..15) placed in SourceOut and matched against RDdest; 0 is reserved.
REQ-002 clock  input  1  ring clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 RingIn / SlotTypeIn / SourceIn  input  32/4/4  upstream ring slot.
REQ-005 RingOut / SlotTypeOut / SourceOut  output  32/4/4  downstream ring slot, registered.
REQ-006 RDreturn / RDdest  input  32/4  read-return word and destination station from the memory controller; RDdest=0 means no word.
REQ-007 req_valid / req_ready  input/output  1/1  core request handshake; transfer when both are high.
REQ-008 req_write / req_addr / req_wdata  input  1/26/128  write flag, cache-line address, write line (word0 = bits 31:0).
REQ-009 rsp_valid / rsp_data / rsp_last  output  1/32/1  read word stream; no back-pressure.
REQ-010 protocol_err  output  1  sticky protocol-violation flag.

Function
REQ-011 Slot codes: Null=7, Token=1, Address=2, WriteData=3; all other types pass through unchanged.
REQ-012 The ring path is a one-cycle register: by default, Out(t+1) = In(t).
REQ-013 An incoming Address or WriteData slot with SourceIn=STATION_ID (own slot returning) is forwarded as Null, with RingOut=0 and SourceOut=0.
REQ-014 On a req handshake the request is latched and req_ready drops; req_ready is high only in IDLE.
REQ-015 FSM states: IDLE, WAIT_TOKEN, SEND, FWD_TOKEN, WAIT_READ.
REQ-016 IDLE -> WAIT_TOKEN on handshake.
REQ-017 In WAIT_TOKEN, a Token slot is absorbed, its RingIn[7:0] is saved, and the FSM goes to SEND. Token passes through untouched in every other state.
REQ-018 SEND emits N slots, N=1 for a read and N=5 for a write, one per cycle starting the cycle after Token capture. Each slot has SourceOut=STATION_ID.
REQ-019 SEND slot contents: the Address slot has RingOut={2'b00, 1'b0, read, 2'b00, addr[25:0]}, with bit 28 = read and bit 29 = 0 (data access). The following WriteData slots carry word0..word3 in order.
REQ-020 Every input slot arriving during SEND shall be Null and is discarded; a non-Null arrival sets protocol_err and is lost.
REQ-021 FWD_TOKEN emits Token with RingOut[7:0] = saved count + N (8-bit wrap) and RingOut[31:8]=0. The FSM then goes to IDLE for a write or WAIT_READ for a read.
REQ-022 WAIT_READ accepts a word in each cycle where RDdest=STATION_ID: rsp_valid=1 and rsp_data=RDreturn, both registered with 1-cycle latency. Gaps between words are allowed.
REQ-023 A 3-bit word counter increments per accepted word. rsp_last=1 on the 8th word, after which the FSM returns to IDLE.
REQ-024 RDdest=STATION_ID outside WAIT_READ sets protocol_err; the word is dropped.
REQ-025 At most one request is outstanding; back-to-back requests each need their own token.

Reset
REQ-026 Reset forces IDLE and clears the word counter and protocol_err.
REQ-027 During reset, req_ready=0, rsp_valid=0, rsp_last=0, SlotTypeOut=Null, RingOut=0 and SourceOut=0.
REQ-028 Reset mid-operation abandons the request with no token re-emitted; the memory controller's token recovery owns that case.

Structure
REQ-029 Slot-type codes and Address-slot bit positions (read=28, instr=29, addr 25:0) live in a shared ring package, also used by the memory multiplexer.
REQ-030 One sub-module, ring_slot_reg, implements the output slot register with a Null-insert override.

Verification
REQ-031 Write: addr=26'h0000100, wdata=128'h4444_3333_2222_1111 per word, Token with count 3.
  - Out = Address 32'h00000100, then WriteData 1111.., 2222.., 3333.., 4444.., then Token with count 8.
  - Source is STATION_ID on all slots and req_ready returns to 1.
REQ-032 Read: addr=26'h3FFFFC0, Token with count 0.
  - Out = Address 32'h13FFFFC0, then Token with count 1.
  - Then 8 RDdest=STATION_ID words 0..7 with 2-cycle gaps: rsp_valid eight times, rsp_last only with word 7.
REQ-033 Own-slot removal: Address with SourceIn=STATION_ID arriving in IDLE -> Null out the next cycle; a foreign Address passes unchanged.
REQ-034 Violations: non-Null slot during SEND, and RDdest match while IDLE -> protocol_err=1 and it stays set until reset.
REQ-035 Reset asserted during WAIT_READ after 3 words -> next cycle IDLE, req_ready=1 after release, counter=0, no rsp_valid.
REQ-036 Token count 8'hFE with a write -> emitted count 8'h03 (wrap).
